ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port round-robin controller for the 32x4 single-port RAM (`ram32x4`). It clears the whole array after every reset and then shares the single RAM port between two requesters. Each requester gets a request/grant handshake and registered read data. It sits between the `ram32x4` instance and the switch/key front-end in `DE1_SoC`, with a second port left for an auto-scan or display engine.

## Interface
Parameters:
- ADDR_W, 5, RAM address width
- DATA_W, 4, RAM data width
- DEPTH, 32, number of words cleared at init (2**ADDR_W)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request from port 0 / 1
- we0 / we1  in  1  1 = write, 0 = read; qualified by req
- addr0 / addr1  in  ADDR_W  request address
- din0 / din1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: the request sampled on the previous edge was accepted
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata for an accepted read is valid
- rdata0 / rdata1  out  DATA_W  read data; holds its value until the next rvalid of the same port
- busy  out  1  high while reset is asserted and during the init sweep
- ram_addr  out  ADDR_W  to RAM addr
- ram_din  out  DATA_W  to RAM din
- ram_w  out  1  to RAM write enable
- ram_dout  in  DATA_W  from RAM dout; combinational read of ram_addr

## Operation
- All outputs are registered.
- Reset values:
  - gnt0/1 = 0, rvalid0/1 = 0, rdata0/1 = 0
  - ram_addr = 0, ram_din = 0, ram_w = 0
  - busy = 1
  - state = INIT, init counter = 0, priority pointer = port 0
- **INIT:**
  - Each cycle drives ram_addr = counter, ram_din = 0, ram_w = 1.
  - The counter increments from 0 to DEPTH-1, then the state moves to RUN.
  - No grants are issued during INIT. Requesters keep req asserted and are served in RUN.
- **RUN:** each cycle the controller samples eligible requests.
  - A port is ineligible in the cycle its gnt is high. Its req in that cycle is ignored, so the requester has time to drop req or change the transaction.
  - One eligible port: that port wins.
  - Both ports eligible: the port named by the priority pointer wins, and the pointer then moves to the other port.
  - Pointer updates only on a two-way conflict. A single-port grant leaves it unchanged.
  - On a win, the next edge registers ram_addr/ram_din/ram_w from the winner's addr/din/we and pulses the winner's gnt.
  - No winner: ram_w = 0 next cycle; ram_addr and ram_din hold.
- Read accepted: in the gnt cycle, ram_dout is captured into the winner's rdata, and rvalid pulses on the following cycle.
- Write accepted: the RAM writes on the edge that ends the gnt cycle. No rvalid is generated for writes.
- Reset is honoured at any time, including mid-INIT or mid-transaction:
  - Outputs go to reset values immediately.
  - Pending reads are dropped with no rvalid.
  - A full INIT sweep restarts after reset is released.

## Timing
- Request sampled on edge N:
  - gnt high in cycle N+1.
  - Write lands in the RAM at edge N+2.
  - Read: rvalid and rdata valid in cycle N+2.
- Read latency is 2 cycles from the sampling edge.
- Peak throughput:
  - One transaction per cycle when the two ports alternate.
  - One transaction per 2 cycles for a single port holding req continuously.
- Read-after-write, same address: a read accepted in the cycle after the write's gnt returns the new data.
- INIT lasts exactly DEPTH cycles after reset release.
  - The first RUN cycle is cycle DEPTH+1.
  - busy is low from cycle DEPTH+1.
  - The earliest gnt is in cycle DEPTH+2.
- Simultaneous requests at reset release: port 0 is granted first, then port 1 in the next cycle.

## Test plan
- **Init clear.** Preload RAM with nonzero data, pulse reset, wait 32 cycles, then read all 32 addresses on port 0. Required: every rdata = 4'h0, and busy is low starting 32 cycles after reset release.
- **Single write/read latency.** Port 0 writes 4'hC to address 5'h01 (gnt0 one cycle after sampling), then reads 5'h01. Required: rvalid0 2 cycles after the read's sampling edge with rdata0 = 4'hC, and gnt1/rvalid1 stay 0.
- **Round-robin contention.** Both ports hold req: port 0 writes 4'hA to 5'h03 and port 1 writes 4'h5 to 5'h04, with pointer = 0. Required: gnt0 then gnt1 in consecutive cycles. After re-requesting, the grant order alternates; no port gets two grants while the other waits.
- **Read-after-write, same address.** Port 1 writes 4'h8 to 5'h1F, and port 0 reads 5'h1F in the cycle after gnt1. Required: rdata0 = 4'h8.
- **Request during INIT.** Assert req1 as a read of 5'h02 immediately after reset release. Required: no gnt1 during the 32 INIT cycles, gnt1 in the first grant cycle afterwards, and rdata1 = 4'h0.
- **Reset mid-operation.** Assert reset at INIT count 10, and again while a read is in flight. Required: all outputs at reset values in the same cycle, no rvalid for the dropped read, and a full 32-cycle sweep restarting after release.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin controller sharing one port of a 32x4 single-port RAM between two requesters.
// Clears the whole array after every reset before serving any request.
module ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_w,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              dbg_state_o
);

  // Handshake: a port presents req/we/addr/din; the request sampled on an edge is
  // accepted when gnt pulses the following cycle. A port's req is ignored while its
  // gnt is high. Reads return rdata with a one-cycle rvalid one cycle after gnt.

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                rd0_q, rd0_d, rd1_q, rd1_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                ram_w_q, ram_w_d;
  logic                el0, el1, win0, win1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      ptr_q      <= 1'b0;
      busy_q     <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rd0_q      <= 1'b0;
      rd1_q      <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_w_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_w_q    <= ram_w_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rd0_d      = 1'b0;
    rd1_d      = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_w_d    = 1'b0;
    win0       = 1'b0;
    win1       = 1'b0;
    el0        = req0 & ~gnt0_q;
    el1        = req1 & ~gnt1_q;
    // rd*_q marks a read's gnt cycle: the RAM is presenting that read's word now.
    rvalid0_d  = rd0_q;
    rvalid1_d  = rd1_q;
    rdata0_d   = rd0_q ? ram_dout : rdata0_q;
    rdata1_d   = rd1_q ? ram_dout : rdata1_q;

    case (state_q)
      ST_INIT: begin
        ram_addr_d = cnt_q;
        ram_din_d  = '0;
        ram_w_d    = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        win0 = el0 & (~el1 | ~ptr_q);
        win1 = el1 & (~el0 |  ptr_q);
        if (el0 && el1) ptr_d = ~ptr_q;
        if (win0) begin
          gnt0_d     = 1'b1;
          rd0_d      = ~we0;
          ram_addr_d = addr0;
          ram_din_d  = din0;
          ram_w_d    = we0;
        end else if (win1) begin
          gnt1_d     = 1'b1;
          rd1_d      = ~we1;
          ram_addr_d = addr1;
          ram_din_d  = din1;
          ram_w_d    = we1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign busy        = busy_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign ram_w       = ram_w_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, transaction-level reference model,
// directed scenarios followed by a randomized phase.
module tb_ram_arbiter;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       preload = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [4:0] addr0 = '0, addr1 = '0;
  logic [3:0] din0 = '0, din1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_w, dbg_state;
  logic [3:0] rdata0, rdata1, ram_din, ram_dout;
  logic [4:0] ram_addr;
  logic [3:0] tb_mem [DEPTH];

  ram_arbiter #(.ADDR_W(5), .DATA_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_w(ram_w), .ram_dout(ram_dout),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // ram32x4 stand-in: combinational read, write on the rising edge.
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < DEPTH; k++) tb_mem[k] <= 4'(k % 15 + 1);
    end else if (ram_w) begin
      tb_mem[ram_addr] <= ram_din;
    end
  end
  assign ram_dout = tb_mem[ram_addr];

  int n_assert = 0;
  int n_fail = 0;

  // Reference model: memory contents, the transaction accepted on the last edge,
  // and the expected values of every output.
  logic [3:0] ref_mem [DEPTH];
  int         init_left;
  int         turn;
  bit         have_prev;
  int         prev_port;
  bit         prev_we;
  logic [4:0] prev_addr;
  logic [3:0] prev_din;
  bit [1:0]   exp_gnt, exp_rvalid;
  logic [3:0] exp_rdata [2];
  logic [4:0] exp_ram_addr;
  logic [3:0] exp_ram_din;
  bit         exp_ram_w, exp_busy;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".gnt0"}, gnt0, exp_gnt[0]);
    chk({tag, ".gnt1"}, gnt1, exp_gnt[1]);
    chk({tag, ".rvalid0"}, rvalid0, exp_rvalid[0]);
    chk({tag, ".rvalid1"}, rvalid1, exp_rvalid[1]);
    chk({tag, ".rdata0"}, rdata0, exp_rdata[0]);
    chk({tag, ".rdata1"}, rdata1, exp_rdata[1]);
    chk({tag, ".busy"}, busy, exp_busy);
    chk({tag, ".ram_w"}, ram_w, exp_ram_w);
    chk({tag, ".ram_addr"}, ram_addr, exp_ram_addr);
    chk({tag, ".ram_din"}, ram_din, exp_ram_din);
  endtask

  task automatic model_reset();
    init_left    = DEPTH;
    turn         = 0;
    have_prev    = 1'b0;
    exp_gnt      = 2'b00;
    exp_rvalid   = 2'b00;
    exp_rdata[0] = 4'h0;
    exp_rdata[1] = 4'h0;
    exp_ram_addr = 5'h00;
    exp_ram_din  = 4'h0;
    exp_ram_w    = 1'b0;
    exp_busy     = 1'b1;
    // The init sweep leaves every word at zero.
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 4'h0;
  endtask

  // One rising edge: retire last edge's transaction, arbitrate the sampled requests, check.
  task automatic tick(string tag);
    int win;
    bit el0, el1;
    @(posedge clk);
    exp_rvalid = 2'b00;
    if (have_prev) begin
      if (prev_we) ref_mem[prev_addr] = prev_din;
      else begin
        exp_rvalid[prev_port] = 1'b1;
        exp_rdata[prev_port]  = ref_mem[prev_addr];
      end
    end
    have_prev = 1'b0;
    win = -1;
    if (init_left > 0) begin
      exp_ram_addr = 5'(DEPTH - init_left);
      exp_ram_din  = 4'h0;
      exp_ram_w    = 1'b1;
      init_left--;
    end else begin
      el0 = req0 && !exp_gnt[0];
      el1 = req1 && !exp_gnt[1];
      if (el0 && el1) begin
        win  = turn;
        turn = 1 - turn;
      end else if (el0) win = 0;
      else if (el1) win = 1;
      exp_ram_w = 1'b0;
    end
    exp_gnt = 2'b00;
    if (win >= 0) begin
      exp_gnt[win] = 1'b1;
      have_prev    = 1'b1;
      prev_port    = win;
      prev_we      = (win == 0) ? we0 : we1;
      prev_addr    = (win == 0) ? addr0 : addr1;
      prev_din     = (win == 0) ? din0 : din1;
      exp_ram_w    = prev_we;
      exp_ram_addr = prev_addr;
      exp_ram_din  = prev_din;
    end
    exp_busy = (init_left > 0);
    #1 check_all(tag);
  endtask

  task automatic apply_reset(string tag, int hold);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all({tag, ".assert"});
    repeat (hold) begin
      @(posedge clk);
      #1 check_all({tag, ".held"});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive0(logic r, logic w, logic [4:0] a, logic [3:0] d);
    req0 = r; we0 = w; addr0 = a; din0 = d;
  endtask

  task automatic drive1(logic r, logic w, logic [4:0] a, logic [3:0] d);
    req1 = r; we1 = w; addr1 = a; din1 = d;
  endtask

  initial begin
    // Power-on reset with the RAM preloaded to nonzero data; port 1 requests during INIT.
    preload = 1'b1;
    apply_reset("por", 1);
    preload = 1'b0;
    drive1(1'b1, 1'b0, 5'h02, 4'h0);
    repeat (DEPTH) tick("init_req");
    tick("init_req.first_run");
    chk("init_req.gnt1_first", gnt1, 1'b1);
    drive1(1'b0, 1'b0, 5'h00, 4'h0);
    tick("init_req.rvalid");
    chk("init_req.rdata1_zero", rdata1, 4'h0);

    // Every word reads back cleared.
    for (int a = 0; a < DEPTH; a++) begin
      drive0(1'b1, 1'b0, 5'(a), 4'h0);
      tick("clear.req");
      drive0(1'b0, 1'b0, 5'h00, 4'h0);
      tick("clear.rsp");
      chk("clear.rdata0_zero", rdata0, 4'h0);
    end

    // Single write then read on port 0.
    drive0(1'b1, 1'b1, 5'h01, 4'hC);
    tick("wr01.gnt");
    drive0(1'b1, 1'b0, 5'h01, 4'h0);
    tick("wr01.idle");
    tick("rd01.gnt");
    drive0(1'b0, 1'b0, 5'h00, 4'h0);
    tick("rd01.rvalid");
    chk("rd01.rdata0", rdata0, 4'hC);

    // Both ports hold req: grants alternate starting with port 0.
    drive0(1'b1, 1'b1, 5'h03, 4'hA);
    drive1(1'b1, 1'b1, 5'h04, 4'h5);
    tick("rr.first");
    chk("rr.first_is_port0", gnt0, 1'b1);
    tick("rr.second");
    chk("rr.second_is_port1", gnt1, 1'b1);
    repeat (6) tick("rr.alternate");
    drive0(1'b1, 1'b0, 5'h03, 4'h0);
    drive1(1'b1, 1'b0, 5'h04, 4'h0);
    repeat (4) tick("rr.readback");
    drive0(1'b0, 1'b0, 5'h00, 4'h0);
    drive1(1'b0, 1'b0, 5'h00, 4'h0);
    repeat (2) tick("rr.drain");

    // Read-after-write at the same address across ports.
    drive1(1'b1, 1'b1, 5'h1F, 4'h8);
    tick("raw.wr_gnt");
    drive1(1'b0, 1'b0, 5'h00, 4'h0);
    drive0(1'b1, 1'b0, 5'h1F, 4'h0);
    tick("raw.rd_gnt");
    drive0(1'b0, 1'b0, 5'h00, 4'h0);
    tick("raw.rvalid");
    chk("raw.rdata0", rdata0, 4'h8);

    // Randomized traffic on both ports.
    for (int i = 0; i < 400; i++) begin
      drive0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      drive1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      tick("rand");
    end
    drive0(1'b0, 1'b0, 5'h00, 4'h0);
    drive1(1'b0, 1'b0, 5'h00, 4'h0);
    tick("rand.drain");

    // Reset in the middle of the init sweep restarts it from address 0.
    apply_reset("rst_a", 0);
    repeat (10) tick("mid_init");
    apply_reset("rst_init10", 2);
    repeat (DEPTH + 1) tick("resweep");

    // Reset while a read is in flight drops it.
    drive0(1'b1, 1'b0, 5'h01, 4'h0);
    tick("inflight.gnt");
    drive0(1'b0, 1'b0, 5'h00, 4'h0);
    apply_reset("rst_inflight", 0);
    repeat (DEPTH + 3) tick("after_drop");

    // Random traffic after the restart, with read-back of the cleared array.
    for (int i = 0; i < 200; i++) begin
      drive0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      drive1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      tick("rand2");
    end
    drive0(1'b0, 1'b0, 5'h00, 4'h0);
    drive1(1'b0, 1'b0, 5'h00, 4'h0);
    repeat (2) tick("final.drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
